// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter with a registered shared data mux.
// Owners are forcibly released after MAX_HOLD consecutive grant cycles.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [CW-1:0]   cnt;
    logic [1:0]      win;
    logic [WIDTH-1:0] dsel;

    // Lowest rotation offset from ptr with a set request wins.
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                win = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        dsel = d0;
        unique case (sel)
            2'd0: dsel = d0;
            2'd1: dsel = d1;
            2'd2: dsel = d2;
            2'd3: dsel = d3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            y       <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            y       <= busy ? dsel : '0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << win;
                        sel   <= win;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[sel] || cnt == LAST) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= sel + 2'd1;
                        cnt     <= '0;
                        timeout <= req[sel];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized self-checking bench for mux4_rr_arbiter.
// Reference model tracks owner/hold count/pointer as plain integers.
module tb_mux4_rr_arbiter;

    localparam int W    = 8;
    localparam int MAXH = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [W-1:0] d[4];
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic         busy;
    logic         timeout;

    int compares = 0;
    int fails    = 0;

    int           m_owner = -1;
    int           m_hold  = 0;
    int           m_ptr   = 0;
    int           m_sel   = 0;
    logic [W-1:0] m_y     = '0;
    logic         m_to    = 1'b0;

    logic [15:0] dut_v;
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAXH)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .d0(d[0]),
        .d1(d[1]),
        .d2(d[2]),
        .d3(d[3]),
        .gnt(gnt),
        .sel(sel),
        .y(y),
        .busy(busy),
        .timeout(timeout)
    );

    assign dut_v = {gnt, sel, busy, y, timeout};

    always_comb begin
        exp_v = '0;
        exp_v[15:12] = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        exp_v[11:10] = 2'(m_sel);
        exp_v[9]     = (m_owner >= 0);
        exp_v[8:1]   = m_y;
        exp_v[0]     = m_to;
    end

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_y     = '0;
        m_to    = 1'b0;
    endtask

    // Advance model with pre-edge inputs, then let the DUT take the edge.
    task automatic cycle();
        m_y  = (m_owner >= 0) ? d[m_sel] : '0;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_sel   = m_owner;
                    m_hold  = 1;
                    break;
                end
            end
        end else if (!req[m_owner] || m_hold == MAXH) begin
            m_to    = req[m_owner];
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
            m_hold++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        #3;
        compares++;
        if (dut_v !== 16'h0) begin
            fails++;
            $display("FAIL reset_async got=%h exp=0000", dut_v);
        end
        @(posedge clk);
        #1;
        compares++;
        if (dut_v !== 16'h0) begin
            fails++;
            $display("FAIL reset_held got=%h exp=0000", dut_v);
        end
        do_reset();
        compares++;
        if (dut_v !== exp_v) begin
            fails++;
            $display("FAIL reset_release got=%h exp=%h", dut_v, exp_v);
        end
    endtask

    task automatic test_all_req();
        int order[$];
        int want[6] = '{0, 1, 2, 3, 0, 1};
        int tos = 0;
        logic [3:0] prev = '0;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 100; c++) begin
            cycle();
            compares++;
            if (dut_v !== exp_v) begin
                fails++;
                $display("FAIL all_req c=%0d got=%h exp=%h",
                         c, dut_v, exp_v);
            end
            if (gnt != 0 && prev == 0) order.push_back(int'(sel));
            if (timeout) tos++;
            prev = gnt;
        end
        for (int i = 0; i < 6; i++) begin
            compares++;
            if (order.size() <= i || order[i] != want[i]) begin
                fails++;
                $display("FAIL all_req_order i=%0d got=%0d exp=%0d",
                         i, (order.size() > i) ? order[i] : -1, want[i]);
            end
        end
        compares++;
        if (tos != 6) begin
            fails++;
            $display("FAIL all_req_timeouts got=%0d exp=6", tos);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) req = 4'b0000;
            cycle();
            compares++;
            if (dut_v !== exp_v) begin
                fails++;
                $display("FAIL single c=%0d got=%h exp=%h",
                         c, dut_v, exp_v);
            end
            compares++;
            if (c < 3 && (gnt !== 4'b0100 || sel !== 2'd2)) begin
                fails++;
                $display("FAIL single_gnt c=%0d got=%b exp=0100", c, gnt);
            end else if (c >= 3 && (gnt !== 4'b0 || timeout !== 1'b0)) begin
                fails++;
                $display("FAIL single_rel c=%0d got=%b exp=0000", c, gnt);
            end
        end
        req = 4'b1111;
        cycle();
        compares++;
        if (gnt !== 4'b1000) begin
            fails++;
            $display("FAIL single_ptr got=%b exp=1000", gnt);
        end
    endtask

    task automatic test_data();
        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'h33;
        d[3] = 8'h44;
        do_reset();
        req = 4'b0010;
        cycle();
        compares++;
        if (gnt !== 4'b0010 || y !== 8'h00) begin
            fails++;
            $display("FAIL data_gnt got=%b/%h exp=0010/00", gnt, y);
        end
        cycle();
        compares++;
        if (y !== 8'h22) begin
            fails++;
            $display("FAIL data_y got=%h exp=22", y);
        end
        req = 4'b0000;
        cycle();
        compares++;
        if (gnt !== 4'b0 || y !== 8'h22) begin
            fails++;
            $display("FAIL data_fall got=%b/%h exp=0000/22", gnt, y);
        end
        cycle();
        compares++;
        if (y !== 8'h00 || dut_v !== exp_v) begin
            fails++;
            $display("FAIL data_zero got=%h exp=%h", dut_v, exp_v);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100;
        cycle();
        req = 4'b0000;
        cycle();
        req = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req = 4'b0001;
            cycle();
            compares++;
            if (dut_v !== exp_v) begin
                fails++;
                $display("FAIL wrap c=%0d got=%h exp=%h", c, dut_v, exp_v);
            end
            if (c == 0) begin
                compares++;
                if (gnt !== 4'b1000) begin
                    fails++;
                    $display("FAIL wrap_first got=%b exp=1000", gnt);
                end
            end
            if (c == 4) begin
                compares++;
                if (gnt !== 4'b0001) begin
                    fails++;
                    $display("FAIL wrap_second got=%b exp=0001", gnt);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        d[1] = 8'h5a;
        req = 4'b0010;
        cycle();
        cycle();
        cycle();
        compares++;
        if (gnt !== 4'b0010 || y !== 8'h5a) begin
            fails++;
            $display("FAIL arst_pre got=%b/%h exp=0010/5a", gnt, y);
        end
        rst = 1'b1;
        #1;
        compares++;
        if (gnt !== 4'b0 || busy !== 1'b0 || y !== '0 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL arst_clear got=%h exp=0000", dut_v);
        end
        model_reset();
        #2;
        rst = 1'b0;
        cycle();
        compares++;
        if (gnt !== 4'b0010 || dut_v !== exp_v) begin
            fails++;
            $display("FAIL arst_regrant got=%h exp=%h", dut_v, exp_v);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 4'b0100;
        cycle();
        req = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            cycle();
            compares++;
            if (gnt !== 4'b0100 || dut_v !== exp_v) begin
                fails++;
                $display("FAIL nopre_hold c=%0d got=%h exp=%h",
                         c, dut_v, exp_v);
            end
        end
        req = 4'b0001;
        cycle();
        compares++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL nopre_bubble got=%b exp=0000", gnt);
        end
        cycle();
        compares++;
        if (gnt !== 4'b0001 || dut_v !== exp_v) begin
            fails++;
            $display("FAIL nopre_next got=%h exp=%h", dut_v, exp_v);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            cycle();
            compares++;
            if (dut_v !== exp_v) begin
                fails++;
                $display("FAIL random c=%0d req=%b got=%h exp=%h",
                         c, req, dut_v, exp_v);
            end
            compares++;
            if (!$onehot0(gnt) || ((gnt != 0) !== busy)) begin
                fails++;
                $display("FAIL random_inv c=%0d gnt=%b busy=%b exp=onehot",
                         c, gnt, busy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) d[i] = '0;
        test_reset();
        test_all_req();
        test_single();
        test_data();
        test_wrap();
        test_async_reset();
        test_no_preempt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compares, fails);
        $finish;
    end

endmodule
